vv_alu_pipe: RTL and testbench

VV_ALU_PIPE -- requirements
Module: vv_alu_pipe

---
 rtl/vv_alu_pipe.sv | 83 ++++++++
 tb/tb_vv_alu_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vv_alu_pipe.sv
// vv_alu_pipe: two-stage elementwise vector ALU with valid/ready handshakes; define VV_ALU_SATURATE_EN to clamp results instead of wrapping
`ifndef BITS
`define BITS 8
`endif
`ifndef VEC_LEN
`define VEC_LEN 4
`endif
module vv_alu_pipe #(
  parameter int IN_BITS = `BITS,
  parameter int OUT_BITS = `BITS,
  parameter int VEC_LEN = `VEC_LEN
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic [2:0] opcode,
  input  logic [VEC_LEN-1:0][IN_BITS-1:0] vec_a,
  input  logic [VEC_LEN-1:0][IN_BITS-1:0] vec_b,
  output logic out_valid,
  input  logic out_ready,
  output logic [VEC_LEN-1:0][OUT_BITS-1:0] out_vec,
  output logic [2:0] out_op
);
  // FW holds any full-precision result (product needs 2*IN_BITS)
  localparam int FW = 2 * IN_BITS > OUT_BITS ? 2 * IN_BITS : OUT_BITS;
`ifdef VV_ALU_SATURATE_EN
  localparam int RW = FW;
`else
  localparam int RW = OUT_BITS;
`endif
  logic s1_valid, s2_load;
  logic [2:0] s1_op;
  logic [VEC_LEN-1:0][IN_BITS-1:0] s1_a, s1_b;
  logic [VEC_LEN-1:0][OUT_BITS-1:0] res;
  assign s2_load = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
    logic signed [FW-1:0] a, b, d;
    logic signed [RW-1:0] full;
    assign a = {{(FW-IN_BITS){s1_a[i][IN_BITS-1]}}, s1_a[i]};
    assign b = {{(FW-IN_BITS){s1_b[i][IN_BITS-1]}}, s1_b[i]};
    assign d = a - b;
    assign full = RW'(s1_op == 3'd0 ? a * b :
                      s1_op == 3'd1 ? a + b :
                      s1_op == 3'd2 ? d :
                      s1_op == 3'd3 ? b - a :
                      s1_op == 3'd4 ? (d[FW-1] ? a : b) :
                      s1_op == 3'd5 ? (d[FW-1] ? b : a) :
                      s1_op == 3'd6 ? (d[FW-1] ? -d : d) : a);
`ifdef VV_ALU_SATURATE_EN
    localparam logic signed [FW-1:0] HI = {{(FW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [FW-1:0] LO = {{(FW-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};
    assign res[i] = full > HI ? {1'b0, {(OUT_BITS-1){1'b1}}} :
                    full < LO ? {1'b1, {(OUT_BITS-1){1'b0}}} : full[OUT_BITS-1:0];
`else
    assign res[i] = full;
`endif
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op <= '0;
      s1_a <= '0;
      s1_b <= '0;
      out_valid <= 1'b0;
      out_vec <= '0;
      out_op <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_op <= opcode;
        s1_a <= vec_a;
        s1_b <= vec_b;
      end else if (s2_load) s1_valid <= 1'b0;
      if (s2_load) begin
        out_valid <= 1'b1;
        out_vec <= res;
        out_op <= s1_op;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vv_alu_pipe.sv
// tb_vv_alu_pipe: directed vectors against a queue-based reference model of vv_alu_pipe
module tb_vv_alu_pipe;
  localparam int IB = 8, OB = 8, VL = 4;
  typedef logic [VL-1:0][IB-1:0] vin_t;
  typedef logic [VL-1:0][OB-1:0] vout_t;
  typedef struct packed { logic [2:0] op; vout_t v; } exp_t;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [2:0] opcode = '0, out_op;
  vin_t vec_a = '0, vec_b = '0;
  vout_t out_vec;
  int checks = 0, errors = 0;
  exp_t q[$];
  int pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};

  always #5 clock = ~clock;

  vv_alu_pipe #(.IN_BITS(IB), .OUT_BITS(OB), .VEC_LEN(VL)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .vec_a(vec_a), .vec_b(vec_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .out_op(out_op)
  );

  function automatic vout_t model(input logic [2:0] op, input vin_t a, input vin_t b);
    vout_t r;
    for (int i = 0; i < VL; i++) begin
      int x, y, z;
      x = int'($signed(a[i]));
      y = int'($signed(b[i]));
      case (op)
        3'd0: z = x * y;
        3'd1: z = x + y;
        3'd2: z = x - y;
        3'd3: z = y - x;
        3'd4: z = x < y ? x : y;
        3'd5: z = x > y ? x : y;
        3'd6: z = x > y ? x - y : y - x;
        default: z = x;
      endcase
`ifdef VV_ALU_SATURATE_EN
      if (z > (1 << (OB - 1)) - 1) z = (1 << (OB - 1)) - 1;
      else if (z < -(1 << (OB - 1))) z = -(1 << (OB - 1));
`endif
      r[i] = z[OB-1:0];
    end
    return r;
  endfunction

  function automatic vin_t pk(input int e0, input int e1, input int e2, input int e3);
    vin_t v;
    v[0] = e0[IB-1:0];
    v[1] = e1[IB-1:0];
    v[2] = e2[IB-1:0];
    v[3] = e3[IB-1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic send(input logic [2:0] op, input vin_t a, input vin_t b);
    bit ok;
    ok = 0;
    opcode = op;
    vec_a = a;
    vec_b = b;
    in_valid = 1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      ok = in_ready;
    end
    chk("send_accept", 64'(ok), 64'd1);
    @(posedge clock);
    #1 in_valid = 0;
  endtask

  // scoreboard: transfers are sampled mid-cycle, ahead of the edge that commits them
  always @(negedge clock) begin
    if (reset) q.delete();
    else begin
      chk("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
        else begin
          chk("out_vec", 64'(out_vec), 64'(q[0].v));
          chk("out_op", 64'(out_op), 64'(q[0].op));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back('{op: opcode, v: model(opcode, vec_a, vec_b)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_vec", 64'(out_vec), 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("pin_add", 64'(model(3'd1, pk(1, 2, 3, 4), pk(10, 20, 30, 40))), 64'(pk(11, 22, 33, 44)));
    chk("pin_min", 64'(model(3'd4, pk(-5, 7, 0, -128), pk(3, -2, 0, 127))), 64'(pk(-5, -2, 0, -128)));
    chk("pin_max", 64'(model(3'd5, pk(-5, 7, 0, -128), pk(3, -2, 0, 127))), 64'(pk(3, 7, 0, 127)));
`ifdef VV_ALU_SATURATE_EN
    chk("pin_mul", 64'(model(3'd0, pk(100, -3, 0, 16), pk(2, 5, 7, 16))), 64'(pk(127, -15, 0, 127)));
    chk("pin_abs", 64'(model(3'd6, pk(-5, 7, 0, -128), pk(3, -2, 0, 127))), 64'(pk(8, 9, 0, 127)));
`else
    chk("pin_mul", 64'(model(3'd0, pk(100, -3, 0, 16), pk(2, 5, 7, 16))), 64'(pk(-56, -15, 0, 0)));
    chk("pin_abs", 64'(model(3'd6, pk(-5, 7, 0, -128), pk(3, -2, 0, 127))), 64'(pk(8, 9, 0, -1)));
`endif
    @(posedge clock);
    #1;
    opcode = 3'd1;
    vec_a = pk(1, 2, 3, 4);
    vec_b = pk(10, 20, 30, 40);
    in_valid = 1;
    @(posedge clock);
    #1 in_valid = 0;
    @(negedge clock);
    chk("lat1_out_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    chk("lat2_out_valid", 64'(out_valid), 64'd1);
    chk("lat2_out_vec", 64'(out_vec), 64'(pk(11, 22, 33, 44)));
    @(posedge clock);
    #1;
    send(3'd0, pk(100, -3, 0, 16), pk(2, 5, 7, 16));
    send(3'd4, pk(-5, 7, 0, -128), pk(3, -2, 0, 127));
    send(3'd5, pk(-5, 7, 0, -128), pk(3, -2, 0, 127));
    send(3'd6, pk(-5, 7, 0, -128), pk(3, -2, 0, 127));
    send(3'd1, pk(127, -128, -1, 100), pk(1, -1, 1, 100));
    send(3'd2, pk(-128, 127, 5, 0), pk(1, -1, 9, -128));
    send(3'd3, pk(-128, 127, 5, 0), pk(1, -1, 9, -128));
    send(3'd7, pk(-128, 127, 5, 0), pk(1, -1, 9, -128));
    repeat (4) @(negedge clock);
    chk("drain_directed", 64'(q.size()), 64'd0);
    @(posedge clock);
    #1;
    fork
      for (int j = 0; j < 8; j++) send(3'(j), pk(j * 3 - 5, 60 - j * 17, -j, 120), pk(j * 11, -j * 7, 3, j * 2));
      for (int c = 0; c < 30; c++) begin
        out_ready = pat[c % 8][0];
        @(posedge clock);
        #1;
      end
    join
    out_ready = 1;
    repeat (4) @(negedge clock);
    chk("drain_stream", 64'(q.size()), 64'd0);
    @(posedge clock);
    #1 out_ready = 0;
    send(3'd1, pk(1, 1, 1, 1), pk(2, 2, 2, 2));
    send(3'd2, pk(9, 9, 9, 9), pk(3, 3, 3, 3));
    reset = 1;
    in_valid = 1;
    opcode = 3'd7;
    @(posedge clock);
    #1;
    reset = 0;
    in_valid = 0;
    out_ready = 1;
    @(negedge clock);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(negedge clock);
    chk("flush_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
